audio_pkt_reader: RTL and testbench

AUDIO_PKT_READER -- requirements
Module: audio_pkt_reader

---
 rtl/audio_pkt_pkg.sv | 22 ++
 rtl/audio_pkt_skid_fifo.sv | 72 +++++++
 rtl/audio_pkt_reader.sv | 154 +++++++++++++++
 tb/tb_audio_pkt_reader.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkt_pkg.sv
// rtl/audio_pkt_pkg.sv - shared constants for the audio packet reader
package audio_pkt_pkg;

    // Reader FSM encoding
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_START     = 2'd1;
    localparam logic [1:0] ST_STREAM    = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    // Skid buffer geometry; the count field must hold 0..SKID_DEPTH
    localparam int         SKID_DEPTH = 4;
    localparam int         SKID_CNT_W = 3;
    localparam logic [2:0] SKID_FULL  = 3'd4;

    // Payload length in bytes for a packet of 'words' words of 'width' bits
    function automatic logic [15:0] pkt_byte_num(input int words, input int width);
        int bytes;
        bytes = words * (width / 8);
        return bytes[15:0];
    endfunction

endpackage

// File: rtl/audio_pkt_skid_fifo.sv
// rtl/audio_pkt_skid_fifo.sv - 4-entry skid FIFO carrying data plus a last flag
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_push, i_push_data,    write one entry (data + last flag)
//   i_push_last
//   i_pop                   remove the head entry
//   o_count                 current occupancy 0..4
//   o_empty                 occupancy is zero
//   o_head_data/o_head_last head entry contents
module audio_pkt_skid_fifo
    import audio_pkt_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_push_last,
    input  logic                  i_pop,
    output logic [SKID_CNT_W-1:0] o_count,
    output logic                  o_empty,
    output logic [DATA_WIDTH-1:0] o_head_data,
    output logic                  o_head_last
);

    logic [DATA_WIDTH-1:0] r_data [SKID_DEPTH];
    logic [SKID_DEPTH-1:0] r_last;
    logic [1:0]            r_wr_ptr;
    logic [1:0]            r_rd_ptr;
    logic [SKID_CNT_W-1:0] r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    // The reader never overfills, but a push into a full buffer is dropped
    // rather than corrupting the head.
    assign w_do_push = i_push && (r_count != SKID_FULL);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_data[i] <= '0;
            end
            r_last   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_data[r_wr_ptr] <= i_push_data;
                r_last[r_wr_ptr] <= i_push_last;
                r_wr_ptr         <= r_wr_ptr + 2'd1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count     = r_count;
    assign o_empty     = (r_count == '0);
    assign o_head_data = r_data[r_rd_ptr];
    assign o_head_last = r_last[r_rd_ptr];

endmodule

// File: rtl/audio_pkt_reader.sv
// rtl/audio_pkt_reader.sv - reads fixed-size audio packets from a FIFO into a UDP stream
//
// Ports:
//   rd_clk, rd_rst          clock, asynchronous active-high reset
//   enable                  permits a new packet to start (sampled in IDLE only)
//   fifo_rd_en/_rd_data     upstream FIFO read strobe and data (RD_LATENCY cycles)
//   fifo_empty              upstream FIFO empty flag
//   fifo_rd_water_level     upstream FIFO occupancy
//   tx_start, tx_byte_num   packet announcement pulse and constant payload length
//   tx_data/valid/ready/last payload stream
//   tx_done                 frame-sent pulse from the transmitter
//   busy, pkt_cnt           not-idle flag and completed packet count
module audio_pkt_reader
    import audio_pkt_pkg::*;
#(
    parameter int          DATA_WIDTH    = 32,
    parameter int          ADDR_WIDTH    = 10,
    parameter int          PKT_WORDS     = 256,
    parameter int          RD_LATENCY    = 2,
    // Value the completed-packet counter takes in reset
    parameter logic [15:0] PKT_CNT_RESET = 16'd0
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  enable,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    input  logic [ADDR_WIDTH:0]   fifo_rd_water_level,
    output logic                  tx_start,
    output logic [15:0]           tx_byte_num,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  tx_last,
    input  logic                  tx_done,
    output logic                  busy,
    output logic [15:0]           pkt_cnt
);

    localparam int            CW          = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] PKT_WORDS_C = CW'(PKT_WORDS);
    localparam logic [CW-1:0] LAST_IDX    = CW'(PKT_WORDS - 1);

    logic [1:0]            r_state;
    logic [CW-1:0]         r_issued;
    logic [CW-1:0]         r_accepted;
    logic [15:0]           r_pkt_cnt;
    // Data-valid and last-word markers travelling alongside the FIFO read latency
    logic [RD_LATENCY-1:0] r_vld_pipe;
    logic [RD_LATENCY-1:0] r_last_pipe;

    logic [2:0]            w_in_flight;
    logic [2:0]            w_outstanding;
    logic [SKID_CNT_W-1:0] w_skid_count;
    logic                  w_skid_empty;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic                  w_head_last;
    logic                  w_hs;
    logic                  w_rd_last;

    always_comb begin
        w_in_flight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_in_flight = w_in_flight + {2'b00, r_vld_pipe[i]};
        end
    end

    // Every read still in the pipeline is guaranteed a skid slot, so the
    // stream can stall on tx_ready without ever dropping a returning word.
    assign w_outstanding = w_in_flight + w_skid_count;
    assign fifo_rd_en    = (r_state == ST_STREAM) && !fifo_empty &&
                           (r_issued < PKT_WORDS_C) && (w_outstanding < SKID_FULL);
    assign w_rd_last     = (r_issued == LAST_IDX);
    assign w_hs          = tx_valid && tx_ready;

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_vld_pipe  <= '0;
            r_last_pipe <= '0;
        end else begin
            r_vld_pipe[0]  <= fifo_rd_en;
            r_last_pipe[0] <= fifo_rd_en && w_rd_last;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_vld_pipe[i]  <= r_vld_pipe[i-1];
                r_last_pipe[i] <= r_last_pipe[i-1];
            end
        end
    end

    audio_pkt_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .i_clk       (rd_clk),
        .i_rst       (rd_rst),
        .i_push      (r_vld_pipe[RD_LATENCY-1]),
        .i_push_data (fifo_rd_data),
        .i_push_last (r_last_pipe[RD_LATENCY-1]),
        .i_pop       (w_hs),
        .o_count     (w_skid_count),
        .o_empty     (w_skid_empty),
        .o_head_data (w_head_data),
        .o_head_last (w_head_last)
    );

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_state    <= ST_IDLE;
            r_issued   <= '0;
            r_accepted <= '0;
            r_pkt_cnt  <= PKT_CNT_RESET;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_issued   <= '0;
                    r_accepted <= '0;
                    if (enable && (fifo_rd_water_level >= PKT_WORDS_C)) begin
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    r_state <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (fifo_rd_en) begin
                        r_issued <= r_issued + CW'(1);
                    end
                    if (w_hs) begin
                        r_accepted <= r_accepted + CW'(1);
                        if (r_accepted == LAST_IDX) begin
                            r_state <= ST_WAIT_DONE;
                        end
                    end
                end
                ST_WAIT_DONE: begin
                    if (tx_done) begin
                        r_state   <= ST_IDLE;
                        r_pkt_cnt <= r_pkt_cnt + 16'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign tx_start    = (r_state == ST_START);
    assign tx_byte_num = pkt_byte_num(PKT_WORDS, DATA_WIDTH);
    assign tx_valid    = !w_skid_empty;
    assign tx_data     = w_head_data;
    assign tx_last     = tx_valid && w_head_last;
    assign busy        = (r_state != ST_IDLE);
    assign pkt_cnt     = r_pkt_cnt;

endmodule

// File: tb/tb_audio_pkt_reader.sv
// tb/tb_audio_pkt_reader.sv - directed self-checking bench for audio_pkt_reader
module tb_audio_pkt_reader;

    logic        rd_clk = 1'b0;
    logic        rd_rst = 1'b1;
    logic        enable = 1'b0;
    logic        fifo_rd_en;
    logic [31:0] fifo_rd_data;
    logic        fifo_empty;
    logic [10:0] fifo_rd_water_level;
    logic        tx_start;
    logic [15:0] tx_byte_num;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        tx_last;
    logic        tx_done = 1'b0;
    logic        busy;
    logic [15:0] pkt_cnt;

    logic        enable2 = 1'b0;
    logic        rd_en2;
    logic        empty2 = 1'b0;
    logic [10:0] level2 = 11'd1;
    logic [31:0] data2 = 32'hCAFE_0001;
    logic        tx_start2;
    logic [15:0] tx_byte_num2;
    logic [31:0] tx_data2;
    logic        tx_valid2;
    logic        tx_ready2 = 1'b1;
    logic        tx_last2;
    logic        tx_done2 = 1'b0;
    logic        busy2;
    logic [15:0] pkt_cnt2;

    always #5 rd_clk = ~rd_clk;

    audio_pkt_reader #(
        .DATA_WIDTH(32), .ADDR_WIDTH(10), .PKT_WORDS(8), .RD_LATENCY(2)
    ) dut (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .enable(enable),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
        .fifo_rd_water_level(fifo_rd_water_level),
        .tx_start(tx_start), .tx_byte_num(tx_byte_num), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last), .tx_done(tx_done),
        .busy(busy), .pkt_cnt(pkt_cnt)
    );

    audio_pkt_reader #(
        .DATA_WIDTH(32), .ADDR_WIDTH(10), .PKT_WORDS(1), .RD_LATENCY(2),
        .PKT_CNT_RESET(16'hFFFF)
    ) dut2 (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .enable(enable2),
        .fifo_rd_en(rd_en2), .fifo_rd_data(data2), .fifo_empty(empty2),
        .fifo_rd_water_level(level2),
        .tx_start(tx_start2), .tx_byte_num(tx_byte_num2), .tx_data(tx_data2),
        .tx_valid(tx_valid2), .tx_ready(tx_ready2), .tx_last(tx_last2), .tx_done(tx_done2),
        .busy(busy2), .pkt_cnt(pkt_cnt2)
    );

    // Upstream FIFO model with a two-cycle registered read path
    logic [31:0] fmem [0:63];
    int          wr_idx = 0;
    int          rd_idx = 0;
    logic        force_empty = 1'b0;
    logic [31:0] d0 = '0;
    logic [31:0] d1 = '0;

    assign fifo_empty          = force_empty || (wr_idx == rd_idx);
    assign fifo_rd_water_level = 11'(wr_idx - rd_idx);
    assign fifo_rd_data        = d1;

    always @(posedge rd_clk) begin
        if (rd_rst) begin
            rd_idx <= wr_idx;
            d0     <= '0;
            d1     <= '0;
        end else begin
            if (fifo_rd_en) begin
                d0     <= fmem[rd_idx[5:0]];
                rd_idx <= rd_idx + 1;
            end
            d1 <= d0;
        end
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] got [0:15];
    int          n_got, n_last, last_at, n_start;
    int          n_stall_bad, n_room_bad, n_pause_bad, first_cyc, last_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] v);
        fmem[wr_idx[5:0]] = v;
        wr_idx++;
    endtask

    task automatic done_pulse();
        @(negedge rd_clk);
        tx_done = 1'b1;
        @(negedge rd_clk);
        tx_done = 1'b0;
        #1;
    endtask

    // mode 0: ready always; 1: ready 1,0,0,1; 2: empty forced 5 cycles after word 3;
    // 3: stop after word 4 is accepted
    task automatic collect(input int mode);
        int   bench_issued;
        int   pause_left;
        logic prev_stall;
        logic [31:0] prev_data;
        logic prev_last;
        logic fin;
        n_got = 0; n_last = 0; last_at = 0; n_start = 0;
        n_stall_bad = 0; n_room_bad = 0; n_pause_bad = 0; first_cyc = 0; last_cyc = 0;
        bench_issued = 0; pause_left = 0; prev_stall = 1'b0; prev_data = '0;
        prev_last = 1'b0; fin = 1'b0;
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            @(negedge rd_clk);
            tx_ready    = (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            force_empty = (pause_left > 0);
            if (pause_left > 0) pause_left--;
            #1;
            if (tx_start) n_start++;
            if (fifo_rd_en && (bench_issued - n_got) >= 4) n_room_bad++;
            if (force_empty && fifo_rd_en) n_pause_bad++;
            if (prev_stall && !(tx_valid && tx_data === prev_data && tx_last === prev_last))
                n_stall_bad++;
            if (tx_valid && tx_ready) begin
                if (n_got < 16) got[n_got[3:0]] = tx_data;
                if (n_got == 0) first_cyc = cyc;
                last_cyc = cyc;
                n_got++;
                if (tx_last) begin
                    n_last++;
                    last_at = n_got;
                    fin = 1'b1;
                end
                if (mode == 3 && n_got == 4) fin = 1'b1;
                if (mode == 2 && n_got == 3) pause_left = 5;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            prev_last  = tx_last;
            if (fifo_rd_en) bench_issued++;
        end
        force_empty = 1'b0;
        chk("collect_finished", 32'(fin), 32'd1);
    endtask

    task automatic check_words(input string tag, input int base, input int count);
        chk({tag, "_count"}, n_got, count);
        for (int i = 0; i < count; i++) begin
            chk({tag, "_word"}, got[i[3:0]], base + i);
        end
    endtask

    initial begin
        int   ns;
        int   idle_bad;
        int   s2;
        logic got2;
        logic [31:0] w2;
        logic l2;

        // reset state
        repeat (3) @(negedge rd_clk);
        #1;
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_last", 32'(tx_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx_data", tx_data, 32'd0);
        chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        chk("byte_num", 32'(tx_byte_num), 32'd32);
        chk("byte_num2", 32'(tx_byte_num2), 32'd4);
        chk("rst_pkt_cnt2", 32'(pkt_cnt2), 32'h0000_FFFF);
        chk("rst_rd_en2", 32'(rd_en2), 32'd0);
        rd_rst = 1'b0;

        // level 7 of 8 must not start a packet
        enable = 1'b1;
        for (int i = 1; i <= 7; i++) push(32'(i));
        ns = 0; idle_bad = 0;
        repeat (6) begin
            @(negedge rd_clk);
            #1;
            if (tx_start) ns++;
            if (fifo_rd_en || busy) idle_bad++;
        end
        chk("lvl7_no_start", ns, 0);
        chk("lvl7_idle", idle_bad, 0);

        // level reaches 8: full-rate packet
        push(32'd8);
        collect(0);
        check_words("p1", 1, 8);
        chk("p1_start", n_start, 1);
        chk("p1_last_cnt", n_last, 1);
        chk("p1_last_at", last_at, 8);
        chk("p1_consecutive", last_cyc - first_cyc, 7);
        chk("p1_room", n_room_bad, 0);
        @(negedge rd_clk);
        #1;
        chk("p1_wait_busy", 32'(busy), 32'd1);
        chk("p1_wait_valid", 32'(tx_valid), 32'd0);
        done_pulse();
        chk("p1_pkt_cnt", 32'(pkt_cnt), 32'd1);
        chk("p1_idle", 32'(busy), 32'd0);

        // tx_done in IDLE is ignored
        done_pulse();
        chk("stray_done", 32'(pkt_cnt), 32'd1);

        // backpressure 1,0,0,1
        for (int i = 1; i <= 8; i++) push(32'(i));
        collect(1);
        check_words("p2", 1, 8);
        chk("p2_start", n_start, 1);
        chk("p2_last_cnt", n_last, 1);
        chk("p2_last_at", last_at, 8);
        chk("p2_stable", n_stall_bad, 0);
        chk("p2_room", n_room_bad, 0);
        done_pulse();
        chk("p2_pkt_cnt", 32'(pkt_cnt), 32'd2);

        // FIFO empty for 5 cycles after word 3
        for (int i = 1; i <= 8; i++) push(32'(i));
        collect(2);
        check_words("p3", 1, 8);
        chk("p3_last_cnt", n_last, 1);
        chk("p3_last_at", last_at, 8);
        chk("p3_no_read_empty", n_pause_bad, 0);
        chk("p3_gap", 32'(last_cyc - first_cyc > 7), 32'd1);
        done_pulse();
        chk("p3_pkt_cnt", 32'(pkt_cnt), 32'd3);

        // reset after word 4
        for (int i = 1; i <= 8; i++) push(32'(i));
        collect(3);
        check_words("p4", 1, 4);
        chk("p4_no_last", n_last, 0);
        @(negedge rd_clk);
        rd_rst = 1'b1;
        @(negedge rd_clk);
        #1;
        chk("mid_rst_valid", 32'(tx_valid), 32'd0);
        chk("mid_rst_last", 32'(tx_last), 32'd0);
        chk("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_data", tx_data, 32'd0);
        chk("mid_rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        rd_rst = 1'b0;
        for (int i = 11; i <= 18; i++) push(32'(i));
        collect(0);
        check_words("p5", 11, 8);
        chk("p5_start", n_start, 1);
        chk("p5_last_cnt", n_last, 1);
        chk("p5_last_at", last_at, 8);
        done_pulse();
        chk("p5_pkt_cnt", 32'(pkt_cnt), 32'd1);

        // single-word packet and counter wrap on the second instance
        @(negedge rd_clk);
        enable2 = 1'b1;
        s2 = 0; got2 = 1'b0; w2 = '0; l2 = 1'b0;
        for (int c = 0; c < 20 && !got2; c++) begin
            @(negedge rd_clk);
            #1;
            if (tx_start2) begin
                s2++;
                enable2 = 1'b0;
            end
            if (tx_valid2 && tx_ready2) begin
                got2 = 1'b1;
                w2 = tx_data2;
                l2 = tx_last2;
            end
        end
        chk("w1_seen", 32'(got2), 32'd1);
        chk("w1_start", s2, 1);
        chk("w1_data", w2, 32'hCAFE_0001);
        chk("w1_last", 32'(l2), 32'd1);
        @(negedge rd_clk);
        tx_done2 = 1'b1;
        @(negedge rd_clk);
        tx_done2 = 1'b0;
        #1;
        chk("wrap_pkt_cnt", 32'(pkt_cnt2), 32'd0);
        chk("wrap_idle", 32'(busy2), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
